keypad_scan_onehot: RTL and testbench

//  Scans a 4x4 active-low matrix keypad and drives onehot[15:0], the 16-bit one-hot key code consumed by onehot2binary.
//  - Drives one row low at a time and samples the four column inputs.
//  - Debounces whole-matrix snapshots.
//  - Holds the code while a key is held; returns 16'h0000 when no key is pressed.
//  - Sits between the board keypad pins and the password/display logic.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/kp_col_sync.sv | 22 ++
 rtl/keypad_scan_onehot.sv | 120 ++++++++++++
 tb/tb_keypad_scan_onehot.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix geometry, key index helper and the one-hot
// codes that onehot2binary decodes.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  localparam logic [15:0] KP_NONE  = 16'h0000;
  localparam logic [15:0] KP_ENTER = 16'h0001;
  localparam logic [15:0] KP_DIG0  = 16'h0008;
  localparam logic [15:0] KP_CLR   = 16'h0100;

  typedef enum logic {
    DB_SETTLE,
    DB_LOCKED
  } db_state_t;

  function automatic int unsigned idx(input int unsigned row, input int unsigned col);
    return row * KP_COLS + col;
  endfunction

  // True when two or more keys are set; ghosting and chords both land here.
  function automatic logic kp_multi(input logic [15:0] v);
    return (v & (v - 16'd1)) != 16'd0;
  endfunction

endpackage

// File: rtl/kp_col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column pins.
// Resets to all-ones, which is the idle (no key) level of the pulled-up columns.
module kp_col_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] col_sync
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      meta     <= col_in;
      col_sync <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_onehot.sv
// 4x4 active-low keypad scanner: rotates a one-cold row drive, snapshots the columns
// once per frame and publishes a debounced one-hot key code with a new-key strobe.
module keypad_scan_onehot
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic        key_pulse
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_FRAMES);

  logic [3:0]    col_sync;
  logic [3:0]    col_act;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    row_idx;
  logic [11:0]   snap;
  logic [15:0]   snapshot;
  logic          slot_end;
  logic          frame_end;

  db_state_t     db_state, db_nxt;
  logic [15:0]   cand, cand_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0]   onehot_nxt;
  logic          valid_nxt;
  logic          pulse_nxt;

  kp_col_sync u_col_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_in   (col_in),
    .col_sync (col_sync)
  );

  assign col_act   = ~col_sync;
  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (row_idx == 2'd3);
  // Row 3 is never stored: its nibble is taken live on the frame-end cycle.
  assign snapshot  = {col_act, snap};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      row_idx  <= 2'd0;
      row_out  <= 4'b1110;
      snap     <= '0;
    end else begin
      if (slot_end) begin
        slot_cnt <= '0;
        row_idx  <= row_idx + 2'd1;
        row_out  <= {row_out[2:0], row_out[3]};
        case (row_idx)
          2'd0:    snap[3:0]  <= col_act;
          2'd1:    snap[7:4]  <= col_act;
          2'd2:    snap[11:8] <= col_act;
          default: ;
        endcase
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_state  <= DB_SETTLE;
      cand      <= KP_NONE;
      cnt       <= '0;
      onehot    <= KP_NONE;
      key_valid <= 1'b0;
      key_pulse <= 1'b0;
    end else begin
      db_state  <= db_nxt;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      onehot    <= onehot_nxt;
      key_valid <= valid_nxt;
      key_pulse <= pulse_nxt;
    end
  end

  always_comb begin
    db_nxt     = db_state;
    cand_nxt   = cand;
    cnt_nxt    = cnt;
    onehot_nxt = onehot;
    valid_nxt  = key_valid;
    pulse_nxt  = 1'b0;
    if (frame_end) begin
      if (snapshot != cand) begin
        cand_nxt = snapshot;
        cnt_nxt  = CW'(1);
        db_nxt   = DB_SETTLE;
      end else if (db_state == DB_SETTLE && cnt < CNT_MAX) begin
        cnt_nxt = cnt + CW'(1);
        if (cnt_nxt == CNT_MAX) begin
          db_nxt = DB_LOCKED;
          // Chords are dropped entirely so the previous code stays visible.
          if (!kp_multi(cand)) begin
            onehot_nxt = cand;
            valid_nxt  = (cand != KP_NONE);
            pulse_nxt  = (cand != KP_NONE) && (cand != onehot);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_onehot.sv
// Randomised scoreboard bench for keypad_scan_onehot with a frame-level keypad model.
module tb_keypad_scan_onehot;
  import keypad_pkg::*;

  localparam int SD    = 4;
  localparam int DF    = 3;
  localparam int FRAME = 4 * SD;

  typedef struct {
    logic [15:0] val;
    bit          pulse;
  } ev_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_pulse;

  int checks = 0;
  int errors = 0;

  logic [15:0] keys      = 16'h0;
  logic [15:0] next_keys = 16'h0;
  logic [15:0] exp_oh    = 16'h0;
  logic [15:0] hist[$];
  ev_t         q[$];
  int          frames = 0;
  int          k;

  always #5 clk = ~clk;

  keypad_scan_onehot #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_in    (col_in),
    .row_out   (row_out),
    .onehot    (onehot),
    .key_valid (key_valid),
    .key_pulse (key_pulse)
  );

  // Passive matrix: a column is pulled low only through a pressed key on the driven row.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] one;
    one = 16'h0001;
    return one << idx(r, c);
  endfunction

  // Accept a frame value once it has been seen on exactly DF consecutive frames.
  task automatic model_frame(input logic [15:0] s);
    int  n;
    bit  run;
    hist.push_back(s);
    if (hist.size() > DF + 1) void'(hist.pop_front());
    n = hist.size();
    run = (n >= DF);
    for (int i = n - DF; run && i < n; i++)
      if (hist[i] != s) run = 0;
    if (run && n == DF + 1 && hist[0] == s) run = 0;
    if (run && $countones(s) <= 1 && s != exp_oh) begin
      q.push_back('{val: s, pulse: (s != 16'h0)});
      exp_oh = s;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // Frame tracker: evaluates the model on each completed frame, then applies the next key set.
  initial begin
    logic [3:0] last_row;
    last_row = 4'b1110;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        hist.delete();
        exp_oh   = 16'h0;
        last_row = row_out;
      end else begin
        if (row_out == 4'b1110 && last_row == 4'b0111) begin
          model_frame(keys);
          keys = next_keys;
          frames++;
        end
        last_row = row_out;
      end
    end
  end

  // Monitor: row rotation, key_valid tracking and scoreboard on every onehot change.
  initial begin
    logic [15:0] prev_oh;
    logic [3:0]  er;
    bit          pend;
    int          win;
    ev_t         ev;
    prev_oh = 16'h0;
    pend    = 0;
    win     = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        prev_oh = onehot;
        pend    = 0;
      end else begin
        er = ~(4'b0001 << ((k / SD) % 4));
        chk("row_out_rotation", row_out, er);
        chk("key_valid_track", key_valid, onehot != 16'h0);
        if (onehot !== prev_oh) begin
          if (q.size() == 0) begin
            chk("onehot_unexpected_change", onehot, prev_oh);
          end else begin
            ev = q.pop_front();
            chk("onehot_value", onehot, ev.val);
            pend = ev.pulse;
            win  = 2;
          end
          prev_oh = onehot;
        end
        if (key_pulse) begin
          if (pend) begin
            chk("key_pulse", key_pulse, 1);
            pend = 0;
          end else begin
            chk("key_pulse_unexpected", key_pulse, 0);
          end
        end else if (pend) begin
          win--;
          if (win == 0) begin
            chk("key_pulse_missing", key_pulse, 1);
            pend = 0;
          end
        end
      end
    end
  end

  task automatic wait_frames(input int n);
    int target;
    int budget;
    target = frames + n;
    budget = (n + 2) * FRAME + 8;
    while (frames < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (frames < target) chk("frame_timeout", frames, target);
    #3;
  endtask

  initial begin
    logic [15:0] rk;
    int          sel;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_row_out", row_out, 4'b1110);
    chk("reset_onehot", onehot, 16'h0);
    chk("reset_key_valid", key_valid, 0);
    chk("reset_key_pulse", key_pulse, 0);
    @(negedge clk);
    rst_n = 1'b1;

    wait_frames(2);
    chk("idle_onehot", onehot, 16'h0);

    next_keys = key(1, 2);
    wait_frames(6);
    chk("press_1_2", onehot, 16'h0040);
    chk("press_1_2_valid", key_valid, 1);
    wait_frames(10);

    next_keys = 16'h0;
    wait_frames(5);
    chk("release_onehot", onehot, 16'h0);
    chk("release_valid", key_valid, 0);
    next_keys = key(3, 3);
    wait_frames(5);
    chk("press_3_3", onehot, 16'h8000);
    next_keys = 16'h0;
    wait_frames(5);

    for (int i = 0; i < 3; i++) begin
      next_keys = key(0, 3);
      wait_frames(2);
      next_keys = 16'h0;
      wait_frames(1);
    end
    wait_frames(1);
    chk("bounce_onehot", onehot, 16'h0);

    next_keys = key(0, 0) | key(2, 3);
    wait_frames(8);
    chk("chord_held", onehot, 16'h0);
    next_keys = key(0, 0);
    wait_frames(5);
    chk("chord_release", onehot, KP_ENTER);
    next_keys = 16'h0;
    wait_frames(5);

    next_keys = key(1, 2);
    wait_frames(6);
    chk("pre_reset_onehot", onehot, 16'h0040);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midslot_row_out", row_out, 4'b1110);
    chk("midslot_onehot", onehot, 16'h0);
    chk("midslot_valid", key_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_frames(6);
    chk("reacquire", onehot, 16'h0040);
    next_keys = 16'h0;
    wait_frames(5);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 3);
      rk  = 16'h0;
      if (sel != 0) rk = key($urandom_range(0, 3), $urandom_range(0, 3));
      if (sel == 3) rk = rk | key($urandom_range(0, 3), $urandom_range(0, 3));
      next_keys = rk;
      wait_frames($urandom_range(1, 5));
    end

    next_keys = 16'h0;
    wait_frames(DF + 3);
    repeat (4) @(posedge clk);
    #3;
    chk("scoreboard_drained", q.size(), 0);
    chk("final_onehot", onehot, exp_oh);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
